// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - carries fetch-time predictions to EX and resolves them
// Flags mispredicts, drives predictor update and fetch redirect, counts branches.
module branch_resolve_unit #(
   parameter int PC_LENGTH = 32,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_valid_if,
   input  logic [PC_LENGTH-1:0] i_pc_if,
   input  logic                 i_pred_taken_if,
   input  logic [PC_LENGTH-1:0] i_pred_target_if,
   input  logic                 i_stall,
   input  logic                 i_is_br_ex,
   input  logic                 i_taken_ex,
   input  logic [PC_LENGTH-1:0] i_target_ex,
   output logic                 o_update,
   output logic                 o_taken,
   output logic [PC_LENGTH-1:0] o_pc_ex,
   output logic [PC_LENGTH-1:0] o_target_pc,
   output logic                 o_flush,
   output logic [PC_LENGTH-1:0] o_redirect_pc,
   output logic [CNT_WIDTH-1:0] o_br_count,
   output logic [CNT_WIDTH-1:0] o_mispred_count
);

   logic                 ifid_valid;
   logic [PC_LENGTH-1:0] ifid_pc;
   logic                 ifid_pred_taken;
   logic [PC_LENGTH-1:0] ifid_pred_target;

   logic                 idex_valid;
   logic [PC_LENGTH-1:0] idex_pc;
   logic                 idex_pred_taken;
   logic [PC_LENGTH-1:0] idex_pred_target;

   logic [PC_LENGTH-1:0] pc_plus4;
   logic                 update;
   logic                 mis_taken;
   logic                 mis_not_taken;
   logic                 alias_hit;
   logic                 flush;

   // EX resolution: a taken outcome is wrong if we predicted fall-through or a different target.
   always_comb begin
      pc_plus4      = idex_pc + PC_LENGTH'(4);
      update        = idex_valid & i_is_br_ex;
      mis_taken     = update & i_taken_ex &
                      (~idex_pred_taken | (idex_pred_target != i_target_ex));
      mis_not_taken = update & ~i_taken_ex & idex_pred_taken;
      alias_hit     = idex_valid & ~i_is_br_ex & idex_pred_taken;
      flush         = mis_taken | mis_not_taken | alias_hit;
   end

   assign o_update      = update;
   assign o_taken       = i_taken_ex;
   assign o_pc_ex       = idex_pc;
   assign o_target_pc   = i_target_ex;
   assign o_flush       = flush;
   assign o_redirect_pc = mis_taken ? i_target_ex : pc_plus4;

   // Valid bits carry the flush/stall/reset priority; payload just follows them.
   always_ff @(posedge clk) begin
      if (rst) begin
         ifid_valid <= 1'b0;
         idex_valid <= 1'b0;
      end else if (flush) begin
         ifid_valid <= 1'b0;
         idex_valid <= 1'b0;
      end else if (i_stall) begin
         idex_valid <= 1'b0;
      end else begin
         ifid_valid <= i_valid_if;
         idex_valid <= ifid_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (!i_stall) begin
         ifid_pc          <= i_pc_if;
         ifid_pred_taken  <= i_pred_taken_if;
         ifid_pred_target <= i_pred_target_if;
      end
      idex_pc          <= ifid_pc;
      idex_pred_taken  <= ifid_pred_taken;
      idex_pred_target <= ifid_pred_target;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_br_count      <= '0;
         o_mispred_count <= '0;
      end else begin
         if (update && (o_br_count != {CNT_WIDTH{1'b1}}))
            o_br_count <= o_br_count + CNT_WIDTH'(1);
         if (flush && (o_mispred_count != {CNT_WIDTH{1'b1}}))
            o_mispred_count <= o_mispred_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed-vector bench for branch_resolve_unit
// Narrow counters let saturation be reached with ordinary traffic.
module tb_branch_resolve_unit;

   localparam int PW = 32;
   localparam int CW = 4;

   logic          clk;
   logic          rst;
   logic          i_valid_if;
   logic [PW-1:0] i_pc_if;
   logic          i_pred_taken_if;
   logic [PW-1:0] i_pred_target_if;
   logic          i_stall;
   logic          i_is_br_ex;
   logic          i_taken_ex;
   logic [PW-1:0] i_target_ex;
   logic          o_update;
   logic          o_taken;
   logic [PW-1:0] o_pc_ex;
   logic [PW-1:0] o_target_pc;
   logic          o_flush;
   logic [PW-1:0] o_redirect_pc;
   logic [CW-1:0] o_br_count;
   logic [CW-1:0] o_mispred_count;

   int vec_count = 0;
   int err_count = 0;

   branch_resolve_unit #(.PC_LENGTH(PW), .CNT_WIDTH(CW)) dut (
      .clk              (clk),
      .rst              (rst),
      .i_valid_if       (i_valid_if),
      .i_pc_if          (i_pc_if),
      .i_pred_taken_if  (i_pred_taken_if),
      .i_pred_target_if (i_pred_target_if),
      .i_stall          (i_stall),
      .i_is_br_ex       (i_is_br_ex),
      .i_taken_ex       (i_taken_ex),
      .i_target_ex      (i_target_ex),
      .o_update         (o_update),
      .o_taken          (o_taken),
      .o_pc_ex          (o_pc_ex),
      .o_target_pc      (o_target_pc),
      .o_flush          (o_flush),
      .o_redirect_pc    (o_redirect_pc),
      .o_br_count       (o_br_count),
      .o_mispred_count  (o_mispred_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_count++;
      if (obs !== exp) begin
         err_count++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic v, input logic [31:0] pc, input logic pt, input logic [31:0] ptg,
                        input logic br, input logic tk, input logic [31:0] tg);
      i_valid_if       = v;
      i_pc_if          = pc;
      i_pred_taken_if  = pt;
      i_pred_target_if = ptg;
      i_is_br_ex       = br;
      i_taken_ex       = tk;
      i_target_ex      = tg;
      #2;
   endtask

   task automatic drain();
      apply(0, 0, 0, 0, 0, 0, 0); go();
      apply(0, 0, 0, 0, 0, 0, 0); go();
   endtask

   initial begin
      rst = 1'b1;
      i_stall = 1'b0;
      apply(0, 0, 0, 0, 1, 1, 32'h40);
      go(); go();
      check("rst_update", o_update, 0);
      check("rst_flush", o_flush, 0);
      check("rst_br_cnt", o_br_count, 0);
      check("rst_mis_cnt", o_mispred_count, 0);
      rst = 1'b0;

      // predicted not taken, resolves taken
      apply(1, 32'h100, 0, 0, 0, 0, 0); go();
      apply(1, 32'h104, 0, 0, 0, 0, 0); go();
      apply(1, 32'h108, 0, 0, 1, 1, 32'h200);
      check("nt_t_update", o_update, 1);
      check("nt_t_taken", o_taken, 1);
      check("nt_t_flush", o_flush, 1);
      check("nt_t_redirect", o_redirect_pc, 32'h200);
      check("nt_t_pc_ex", o_pc_ex, 32'h100);
      check("nt_t_target", o_target_pc, 32'h200);
      go();
      apply(1, 32'h200, 0, 0, 1, 1, 32'h999);
      check("kill1_update", o_update, 0);
      check("kill1_flush", o_flush, 0);
      check("nt_t_br_cnt", o_br_count, 1);
      check("nt_t_mis_cnt", o_mispred_count, 1);
      go();
      apply(1, 32'h204, 0, 0, 1, 1, 32'h999);
      check("kill2_update", o_update, 0);
      check("kill2_flush", o_flush, 0);
      go();
      apply(0, 0, 0, 0, 0, 0, 0);
      check("refetch_pc_ex", o_pc_ex, 32'h200);
      go();
      drain();

      // correctly predicted taken
      apply(1, 32'h140, 1, 32'h180, 0, 0, 0); go();
      apply(0, 0, 0, 0, 0, 0, 0); go();
      apply(0, 0, 0, 0, 1, 1, 32'h180);
      check("t_t_update", o_update, 1);
      check("t_t_flush", o_flush, 0);
      go();
      apply(0, 0, 0, 0, 0, 0, 0);
      check("t_t_br_cnt", o_br_count, 2);
      check("t_t_mis_cnt", o_mispred_count, 1);
      drain();

      // predicted taken, resolves not taken
      apply(1, 32'h1C0, 1, 32'h300, 0, 0, 0); go();
      apply(0, 0, 0, 0, 0, 0, 0); go();
      apply(0, 0, 0, 0, 1, 0, 32'h300);
      check("t_nt_flush", o_flush, 1);
      check("t_nt_redirect", o_redirect_pc, 32'h1C4);
      go();
      drain();

      // predicted taken, wrong target
      apply(1, 32'h1C0, 1, 32'h300, 0, 0, 0); go();
      apply(0, 0, 0, 0, 0, 0, 0); go();
      apply(0, 0, 0, 0, 1, 1, 32'h340);
      check("tgt_flush", o_flush, 1);
      check("tgt_redirect", o_redirect_pc, 32'h340);
      go();
      apply(0, 0, 0, 0, 0, 0, 0);
      check("tgt_br_cnt", o_br_count, 4);
      check("tgt_mis_cnt", o_mispred_count, 3);
      drain();

      // BTB alias on a non-branch
      apply(1, 32'h0FC, 1, 32'h500, 0, 0, 0); go();
      apply(0, 0, 0, 0, 0, 0, 0); go();
      apply(0, 0, 0, 0, 0, 1, 32'h500);
      check("alias_update", o_update, 0);
      check("alias_flush", o_flush, 1);
      check("alias_redirect", o_redirect_pc, 32'h100);
      go();
      apply(0, 0, 0, 0, 0, 0, 0);
      check("alias_br_cnt", o_br_count, 4);
      check("alias_mis_cnt", o_mispred_count, 4);
      drain();

      // two-cycle stall with a branch held in IF/ID
      apply(1, 32'h400, 0, 0, 0, 0, 0); go();
      i_stall = 1'b1;
      apply(1, 32'h404, 0, 0, 1, 0, 0);
      check("stall1_update", o_update, 0);
      go();
      apply(1, 32'h404, 0, 0, 1, 0, 0);
      check("stall2_update", o_update, 0);
      go();
      i_stall = 1'b0;
      apply(1, 32'h404, 0, 0, 1, 0, 0);
      check("stall3_update", o_update, 0);
      go();
      apply(1, 32'h408, 0, 0, 1, 0, 32'h999);
      check("post_stall_update", o_update, 1);
      check("post_stall_pc_ex", o_pc_ex, 32'h400);
      check("post_stall_flush", o_flush, 0);
      go();
      // mispredict while stalled: flush must still clear both stages
      i_stall = 1'b1;
      apply(1, 32'h40C, 0, 0, 1, 1, 32'h600);
      check("stall_mis_flush", o_flush, 1);
      check("stall_mis_redirect", o_redirect_pc, 32'h600);
      go();
      i_stall = 1'b0;
      apply(0, 0, 0, 0, 1, 1, 32'h999);
      check("stall_kill1_update", o_update, 0);
      check("stall_mis_br_cnt", o_br_count, 6);
      check("stall_mis_mis_cnt", o_mispred_count, 5);
      go();
      apply(0, 0, 0, 0, 1, 1, 32'h999);
      check("stall_kill2_update", o_update, 0);
      check("stall_kill2_flush", o_flush, 0);
      go();
      drain();

      // pc + 4 wraps at the top of the address space
      apply(1, 32'hFFFF_FFFC, 1, 32'h10, 0, 0, 0); go();
      apply(0, 0, 0, 0, 0, 0, 0); go();
      apply(0, 0, 0, 0, 1, 0, 32'h10);
      check("wrap_flush", o_flush, 1);
      check("wrap_redirect", o_redirect_pc, 32'h0);
      go();
      drain();

      // counters saturate at all-ones (7/6 before, +10 events each)
      for (int n = 0; n < 10; n++) begin
         apply(1, 32'h800 + 32'(n * 16), 0, 0, 0, 0, 0); go();
         apply(0, 0, 0, 0, 0, 0, 0); go();
         apply(0, 0, 0, 0, 1, 1, 32'h900); go();
      end
      apply(0, 0, 0, 0, 0, 0, 0);
      check("sat_br_cnt", o_br_count, 32'hF);
      check("sat_mis_cnt", o_mispred_count, 32'hF);
      drain();

      // reset asserted during a flush cycle
      apply(1, 32'hA00, 0, 0, 0, 0, 0); go();
      apply(1, 32'hA04, 0, 0, 0, 0, 0); go();
      apply(1, 32'hA08, 0, 0, 1, 1, 32'hB00);
      check("rst_flush_pre", o_flush, 1);
      rst = 1'b1;
      go();
      rst = 1'b0;
      apply(1, 32'hA0C, 1, 32'hC00, 1, 1, 32'hB00);
      check("rst_mid_flush", o_flush, 0);
      check("rst_mid_update", o_update, 0);
      check("rst_mid_br_cnt", o_br_count, 0);
      check("rst_mid_mis_cnt", o_mispred_count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-side companion to the branch predictor. Carries each fetched PC's prediction (taken bit and predicted target) through IF/ID and ID/EX tracking registers.
- In EX, compares the prediction against the resolved outcome. Drives the predictor's update interface (update, taken, pc_ex, target_pc) and issues flush and redirect to fetch.
- Keeps saturating branch and mispredict counters for performance measurement.

Parameters:
- PC_LENGTH, 32, PC and target address width.
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid_if  in  1  a real instruction is in IF this cycle.
- i_pc_if  in  PC_LENGTH  PC of the IF instruction.
- i_pred_taken_if  in  1  predictor redirect decision for i_pc_if (BTB hit AND predicted taken).
- i_pred_target_if  in  PC_LENGTH  predicted target for i_pc_if.
- i_stall  in  1  hazard stall: hold IF/ID, insert bubble into ID/EX.
- i_is_br_ex  in  1  instruction in EX is a B-type or J-type.
- i_taken_ex  in  1  resolved direction; J-type always 1.
- i_target_ex  in  PC_LENGTH  resolved target address.
- o_update  out  1  predictor update strobe.
- o_taken  out  1  resolved direction to the predictor.
- o_pc_ex  out  PC_LENGTH  PC of the EX instruction.
- o_target_pc  out  PC_LENGTH  resolved target to the BTB.
- o_flush  out  1  kill IF/ID and ID/EX contents; redirect fetch.
- o_redirect_pc  out  PC_LENGTH  fetch PC for the next cycle when o_flush=1.
- o_br_count  out  CNT_WIDTH  resolved branches and jumps.
- o_mispred_count  out  CNT_WIDTH  mispredictions, including aliases.

Behaviour:
- Tracking registers:
  - IF/ID and ID/EX each hold {valid, pc, pred_taken, pred_target}.
  - Every edge: ID/EX <- IF/ID and IF/ID <- IF inputs, unless overridden by the priority rules below.
- Priority, highest first:
  - rst: both valid bits and both counters cleared.
  - o_flush: IF/ID.valid <- 0 and ID/EX.valid <- 0. Flush wins over i_stall.
  - i_stall: IF/ID holds its value; ID/EX.valid <- 0 (bubble).
  - Otherwise: normal advance.
- EX evaluation is combinational from ID/EX and the EX inputs. Let v = ID/EX.valid.
- o_update = v & i_is_br_ex. o_taken = i_taken_ex. o_target_pc = i_target_ex. o_pc_ex = ID/EX.pc.
- Mispredict cases (o_flush=1):
  - Branch, actual taken, predicted not taken: v & i_is_br_ex & i_taken_ex & !pred_taken. Redirect = i_target_ex.
  - Branch, actual taken, wrong target: v & i_is_br_ex & i_taken_ex & pred_taken & (pred_target != i_target_ex). Redirect = i_target_ex.
  - Branch, actual not taken, predicted taken: v & i_is_br_ex & !i_taken_ex & pred_taken. Redirect = pc + 4.
  - BTB alias on a non-branch: v & !i_is_br_ex & pred_taken. Redirect = pc + 4; o_update stays 0.
- pc + 4 wraps modulo 2^PC_LENGTH. Target comparison uses all PC_LENGTH bits.
- In every other case o_flush=0 and o_redirect_pc = pc + 4 (don't-care for fetch).
- Latency:
  - Misprediction is detected in the cycle the instruction occupies EX.
  - Fetch uses o_redirect_pc the next cycle.
  - The two younger instructions are killed at that same edge.
  - Penalty is exactly 2 cycles.
- Counters, incremented at the edge:
  - o_br_count += 1 when o_update=1.
  - o_mispred_count += 1 when o_flush=1.
  - Both saturate at all-ones; no wrap.
- Reset:
  - All outputs driven from a non-valid ID/EX: o_update=0, o_flush=0, counters=0.
  - o_pc_ex and o_redirect_pc are don't-care while invalid.
  - Reset mid-flush discards the flush. The first fetch after reset is owned by the PC register, not by this block.
- Bubbles (valid=0) never update, never flush, and never count, regardless of i_is_br_ex.

Test Plan:
- Branch at 0x100, predicted not-taken, resolves taken to 0x200 -> in its EX cycle o_update=1, o_taken=1, o_flush=1, o_redirect_pc=0x200; next 2 cycles' entries invalid; o_mispred_count=1, o_br_count=1.
- Branch at 0x140, predicted taken to 0x180, resolves taken to 0x180 -> o_update=1, o_flush=0; br_count increments, mispred_count unchanged.
- Branch at 0x1C0, predicted taken to 0x300, resolves not-taken -> o_flush=1, o_redirect_pc=0x1C4. Same branch predicted taken to 0x300, resolves taken to 0x340 -> o_flush=1, o_redirect_pc=0x340.
- Non-branch at 0x0FC with pred_taken=1 (alias) -> o_update=0, o_flush=1, o_redirect_pc=0x100, mispred_count+1, br_count unchanged.
- i_stall=1 for 2 cycles with branch in IF/ID -> ID/EX gets 2 bubbles (no update); branch reaches EX one cycle after the stall drops. i_stall=1 in the same cycle as a mispredict -> both stages still cleared.
- PC=0xFFFFFFFC predicted taken, not-taken resolve -> o_redirect_pc=0x00000000. Counter forced to all-ones -> stays all-ones on further events. rst asserted during a flush cycle -> next cycle o_flush=0 and counters 0.
